// File: rtl/reg16_arbiter_if.sv
// Bus bundle between four requesters and the reg16_arbiter register bank.
// The master side drives the requests, and the slave side returns grants, acks and data.
interface reg16_arbiter_if;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned NREGS = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 2;

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       wr;
    logic [NREQ*AW-1:0]    addr;
    logic [NREQ*DW-1:0]    wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [DW-1:0]         rdata;
    logic [NREGS*DW-1:0]   regs;
    logic                  busy;

    modport master (output req, wr, addr, wdata, input gnt, ack, rdata, regs, busy);
    modport slave  (input req, wr, addr, wdata, output gnt, ack, rdata, regs, busy);
endinterface

// File: rtl/reg16_arbiter.sv
// Round-robin arbiter that gives one requester at a time a single read or write
// access to a bank of four 16-bit registers.
module reg16_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NREGS = 4
) (
    input  logic           clk,
    input  logic           rst,
    reg16_arbiter_if.slave bus
);
    localparam int unsigned DW = 16;
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned AW = $clog2(NREGS);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RELEASE} state_e;

    state_e          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   owner_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] ack_q;
    logic            busy_q;
    logic [DW-1:0]   rdata_q;
    logic [DW-1:0]   bank_q [NREGS];

    logic [IW-1:0]   idx_c;
    logic [IW-1:0]   pick_c;
    logic            any_c;
    logic [AW-1:0]   addr_c;
    logic [DW-1:0]   wdata_c;

    // First requesting index found when scanning upward from the round-robin pointer.
    always_comb begin
        idx_c  = ptr_q;
        pick_c = ptr_q;
        any_c  = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx_c = ptr_q + IW'(k);
            if (!any_c && bus.req[idx_c]) begin
                any_c  = 1'b1;
                pick_c = idx_c;
            end
        end
    end

    assign addr_c  = bus.addr[AW*owner_q +: AW];
    assign wdata_c = bus.wdata[DW*owner_q +: DW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            for (int k = 0; k < int'(NREGS); k++) begin
                bank_q[k] <= '0;
            end
        end else begin
            ack_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (any_c) begin
                        owner_q <= pick_c;
                        gnt_q   <= NREQ'(1) << pick_c;
                        busy_q  <= 1'b1;
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (bus.wr[owner_q]) begin
                        bank_q[addr_c] <= wdata_c;
                    end else begin
                        rdata_q <= bank_q[addr_c];
                    end
                    ack_q   <= NREQ'(1) << owner_q;
                    ptr_q   <= owner_q + IW'(1);
                    state_q <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Grant is held for as long as the owner keeps its request up.
                    if (!bus.req[owner_q]) begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
    assign bus.rdata = rdata_q;

    for (genvar k = 0; k < int'(NREGS); k++) begin : g_regs
        assign bus.regs[DW*k +: DW] = bank_q[k];
    end
endmodule

// File: tb/tb_reg16_arbiter.sv
// Testbench for reg16_arbiter: a directed vector table, hand-written corner sequences,
// and a randomized run checked against a transaction-level reference model.
module tb_reg16_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    reg16_arbiter_if bus ();

    reg16_arbiter #(.NREQ(4), .NREGS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  wr;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic        busy;
        logic [15:0] rdata;
        logic [63:0] regs;
    } vec_t;

    vec_t vt [15];

    // Reference model: owner (-1 = none), whether its access is done, pointer, memory.
    int          m_owner;
    bit          m_done;
    int          m_ptr;
    logic [15:0] m_mem [4];
    logic [15:0] m_rdata;
    logic [3:0]  m_ack;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] wr, input logic [7:0] addr,
                         input logic [63:0] wdata);
        bus.req   = req;
        bus.wr    = wr;
        bus.addr  = addr;
        bus.wdata = wdata;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(4'h0, 4'h0, 8'h00, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_done  = 1'b0;
        m_ptr   = 0;
        m_rdata = '0;
        m_ack   = '0;
        for (int k = 0; k < 4; k++) m_mem[k] = '0;
    endtask

    task automatic model_edge(input logic [3:0] req, input logic [3:0] wr, input logic [7:0] addr,
                              input logic [63:0] wdata);
        int a;
        m_ack = '0;
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++)
                if (m_owner < 0 && req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
            m_done = 1'b0;
        end else if (!m_done) begin
            a = int'(addr[2*m_owner +: 2]);
            if (wr[m_owner]) m_mem[a] = wdata[16*m_owner +: 16];
            else             m_rdata = m_mem[a];
            m_ack[m_owner] = 1'b1;
            m_ptr  = (m_owner + 1) % 4;
            m_done = 1'b1;
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  prev_gnt;
        logic [3:0]  exp_gnt;
        logic [3:0]  rq;
        int          got [$];

        vt[0]  = '{4'b0010, 4'b0010, 8'h0C, 64'h0000_0000_1234_0000, 4'b0010, 4'b0000, 1'b1, 16'h0000, 64'h0};
        vt[1]  = '{4'b0010, 4'b0010, 8'h0C, 64'h0000_0000_1234_0000, 4'b0010, 4'b0010, 1'b1, 16'h0000, 64'h1234_0000_0000_0000};
        vt[2]  = '{4'b0000, 4'b0000, 8'h00, 64'h0, 4'b0000, 4'b0000, 1'b0, 16'h0000, 64'h1234_0000_0000_0000};
        vt[3]  = '{4'b0010, 4'b0000, 8'h0C, 64'h0, 4'b0010, 4'b0000, 1'b1, 16'h0000, 64'h1234_0000_0000_0000};
        vt[4]  = '{4'b0010, 4'b0000, 8'h0C, 64'h0, 4'b0010, 4'b0010, 1'b1, 16'h1234, 64'h1234_0000_0000_0000};
        vt[5]  = '{4'b0000, 4'b0000, 8'h00, 64'h0, 4'b0000, 4'b0000, 1'b0, 16'h1234, 64'h1234_0000_0000_0000};
        vt[6]  = '{4'b0100, 4'b0100, 8'h10, 64'h0000_BEEF_0000_0000, 4'b0100, 4'b0000, 1'b1, 16'h1234, 64'h1234_0000_0000_0000};
        vt[7]  = '{4'b0100, 4'b0100, 8'h10, 64'h0000_BEEF_0000_0000, 4'b0100, 4'b0100, 1'b1, 16'h1234, 64'h1234_0000_BEEF_0000};
        vt[8]  = '{4'b0000, 4'b0000, 8'h00, 64'h0, 4'b0000, 4'b0000, 1'b0, 16'h1234, 64'h1234_0000_BEEF_0000};
        vt[9]  = '{4'b0101, 4'b0000, 8'h01, 64'h0, 4'b0001, 4'b0000, 1'b1, 16'h1234, 64'h1234_0000_BEEF_0000};
        vt[10] = '{4'b0101, 4'b0000, 8'h01, 64'h0, 4'b0001, 4'b0001, 1'b1, 16'hBEEF, 64'h1234_0000_BEEF_0000};
        vt[11] = '{4'b0100, 4'b0000, 8'h01, 64'h0, 4'b0000, 4'b0000, 1'b0, 16'hBEEF, 64'h1234_0000_BEEF_0000};
        vt[12] = '{4'b0100, 4'b0000, 8'h00, 64'h0, 4'b0100, 4'b0000, 1'b1, 16'hBEEF, 64'h1234_0000_BEEF_0000};
        vt[13] = '{4'b0100, 4'b0000, 8'h00, 64'h0, 4'b0100, 4'b0100, 1'b1, 16'h0000, 64'h1234_0000_BEEF_0000};
        vt[14] = '{4'b0000, 4'b0000, 8'h00, 64'h0, 4'b0000, 4'b0000, 1'b0, 16'h0000, 64'h1234_0000_BEEF_0000};

        // Reset state while rst is held low.
        drive(4'h0, 4'h0, 8'h00, 64'h0);
        @(negedge clk);
        @(negedge clk);
        check("reset_gnt", 64'(bus.gnt), 64'h0);
        check("reset_ack", 64'(bus.ack), 64'h0);
        check("reset_busy", 64'(bus.busy), 64'h0);
        check("reset_rdata", 64'(bus.rdata), 64'h0);
        check("reset_regs", bus.regs, 64'h0);
        rst = 1'b1;

        // Directed table: write/read by requester 1, write by 2, wrap from ptr 3 to owner 0 then 2.
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].req, vt[i].wr, vt[i].addr, vt[i].wdata);
            tick();
            check($sformatf("vec%0d_gnt", i), 64'(bus.gnt), 64'(vt[i].gnt));
            check($sformatf("vec%0d_ack", i), 64'(bus.ack), 64'(vt[i].ack));
            check($sformatf("vec%0d_busy", i), 64'(bus.busy), 64'(vt[i].busy));
            check($sformatf("vec%0d_rdata", i), 64'(bus.rdata), 64'(vt[i].rdata));
            check($sformatf("vec%0d_regs", i), bus.regs, vt[i].regs);
        end

        // Async reset between edges clears bank and grant immediately.
        do_reset();
        drive(4'b0001, 4'b0001, 8'h02, 64'h0000_0000_0000_BEEF);
        tick();
        tick();
        check("rst_pre_regs", bus.regs, 64'h0000_BEEF_0000_0000);
        check("rst_pre_gnt", 64'(bus.gnt), 64'h1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_regs", bus.regs, 64'h0);
        check("rst_async_gnt", 64'(bus.gnt), 64'h0);
        check("rst_async_rdata", 64'(bus.rdata), 64'h0);
        check("rst_async_busy", 64'(bus.busy), 64'h0);
        drive(4'h0, 4'h0, 8'h00, 64'h0);
        #1 rst = 1'b1;
        @(negedge clk);

        // Owner holds its request after ack: grant held, no repeat ack, requester 3 waits.
        do_reset();
        drive(4'b1010, 4'b0000, 8'h00, 64'h0);
        tick();
        check("hold_gnt1", 64'(bus.gnt), 64'b0010);
        tick();
        check("hold_ack1", 64'(bus.ack), 64'b0010);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("hold%0d_gnt", c), 64'(bus.gnt), 64'b0010);
            check($sformatf("hold%0d_busy", c), 64'(bus.busy), 64'h1);
            check($sformatf("hold%0d_ack", c), 64'(bus.ack), 64'h0);
        end
        drive(4'b1000, 4'b0000, 8'h00, 64'h0);
        tick();
        check("hold_release_gnt", 64'(bus.gnt), 64'h0);
        check("hold_release_busy", 64'(bus.busy), 64'h0);
        tick();
        check("hold_next_gnt", 64'(bus.gnt), 64'b1000);
        tick();
        check("hold_next_ack", 64'(bus.ack), 64'b1000);
        drive(4'h0, 4'h0, 8'h00, 64'h0);
        tick();

        // Reset during the access cycle of a write: nothing lands, no ack.
        do_reset();
        drive(4'b0001, 4'b0001, 8'h00, 64'h0000_0000_0000_AAAA);
        tick();
        check("midrst_gnt", 64'(bus.gnt), 64'h1);
        #2 rst = 1'b0;
        drive(4'h0, 4'h0, 8'h00, 64'h0);
        @(negedge clk);
        check("midrst_ack", 64'(bus.ack), 64'h0);
        check("midrst_regs", bus.regs, 64'h0);
        rst = 1'b1;
        tick();
        check("midrst_ack_after", 64'(bus.ack), 64'h0);
        check("midrst_reg0_after", 64'(bus.regs[15:0]), 64'h0);

        // Full contention: every owner drops req for one cycle after its ack.
        do_reset();
        drive(4'hF, 4'h0, 8'h00, 64'h0);
        prev_gnt = '0;
        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            tick();
            check("contend_onehot", 64'($onehot0(bus.gnt)), 64'h1);
            if (bus.gnt != 4'h0 && prev_gnt == 4'h0)
                for (int k = 0; k < 4; k++) if (bus.gnt[k]) got.push_back(k);
            prev_gnt = bus.gnt;
            bus.req  = 4'hF & ~bus.ack;
        end
        check("contend_count", 64'(got.size()), 64'd5);
        for (int k = 0; k < got.size(); k++)
            check($sformatf("contend_owner%0d", k), 64'(got[k]), 64'(k % 4));

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        rq = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 4; k++) if ($urandom_range(3) == 0) rq[k] = ~rq[k];
            drive(rq, 4'($urandom), 8'($urandom), {$urandom, $urandom});
            @(posedge clk);
            model_edge(bus.req, bus.wr, bus.addr, bus.wdata);
            @(negedge clk);
            exp_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
            check("rand_gnt", 64'(bus.gnt), 64'(exp_gnt));
            check("rand_ack", 64'(bus.ack), 64'(m_ack));
            check("rand_busy", 64'(bus.busy), 64'(m_owner >= 0));
            check("rand_rdata", 64'(bus.rdata), 64'(m_rdata));
            check("rand_regs", bus.regs, {m_mem[3], m_mem[2], m_mem[1], m_mem[0]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
